// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
// Contents: matrix geometry constants, the scanner FSM state encoding and
// a row-index to one-hot row-drive helper.
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    typedef enum logic [0:0] {
        SCAN    = 1'b0,
        COMPARE = 1'b1
    } kp_state_e;

    function automatic logic [KP_ROWS-1:0] row_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix bundle between the scanner and the physical keypad / core.
//   col_in     : raw column sense, 1 = key closed in the driven row
//   row_out    : one-hot row drive
//   key_state  : debounced pressed map, bit (row*4+col)
//   key_strobe : one-cycle pulse whenever key_state changes
// Modports: master = scanner side, slave = keypad/core side.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [KP_COLS-1:0]         col_in;
    logic [KP_ROWS-1:0]         row_out;
    logic [KP_ROWS*KP_COLS-1:0] key_state;
    logic                       key_strobe;

    modport master (
        input  col_in,
        output row_out,
        output key_state,
        output key_strobe
    );

    modport slave (
        output col_in,
        input  row_out,
        input  key_state,
        input  key_strobe
    );

endinterface

// File: rtl/keypad_scanner_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous inputs.
// Ports:
//   clk_i  : sampling clock
//   nrst_i : asynchronous active-low reset, clears both stages
//   d_i    : asynchronous input bus
//   q_o    : synchronized output bus (two clocks of latency)
module sync2
    import keypad_pkg::*;
#(
    parameter int W = KP_COLS
) (
    input  logic         clk_i,
    input  logic         nrst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with whole-scan debouncing.
// Each row is driven for SETTLE_CYCLES clocks, then the synchronized columns
// are captured into a 16-bit scan image. After row 3 a one-cycle COMPARE
// state checks the image against the running candidate; DEBOUNCE_SCANS
// identical scans in a row publish the candidate on key_state.
// Ports:
//   clk  : system clock, rising edge
//   nrst : asynchronous active-low reset
//   kp   : keypad bundle (master side): col_in in; row_out, key_state,
//          key_strobe out
// Parameters:
//   SETTLE_CYCLES  : clocks per row before sampling, 2..255
//   DEBOUNCE_SCANS : identical scans required for an update, 2..15
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             nrst,
    keypad_scanner_if.master kp
);

    localparam logic [0:0] ST_SCAN    = SCAN;
    localparam logic [0:0] ST_COMPARE = COMPARE;

    localparam int         NKEYS       = KP_ROWS * KP_COLS;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] DEB_LAST    = 4'(DEBOUNCE_SCANS - 1);
    localparam logic [3:0] DEB_FULL    = 4'(DEBOUNCE_SCANS);

    logic [KP_COLS-1:0] col_sync;

    logic [0:0]       state_q,    state_d;
    logic [1:0]       row_q,      row_d;
    logic [7:0]       cnt_q,      cnt_d;
    logic [NKEYS-1:0] scan_buf_q, scan_buf_d;
    logic [NKEYS-1:0] cand_q,     cand_d;
    logic [3:0]       stable_q,   stable_d;
    logic [NKEYS-1:0] key_q,      key_d;
    logic             strobe_q,   strobe_d;

    sync2 #(
        .W (KP_COLS)
    ) u_col_sync (
        .clk_i  (clk),
        .nrst_i (nrst),
        .d_i    (kp.col_in),
        .q_o    (col_sync)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        scan_buf_d = scan_buf_q;
        cand_d     = cand_q;
        stable_d   = stable_q;
        key_d      = key_q;
        strobe_d   = 1'b0;

        case (state_q)
            ST_SCAN: begin
                if (cnt_q == SETTLE_LAST) begin
                    scan_buf_d[int'(row_q)*KP_COLS +: KP_COLS] = col_sync;
                    cnt_d = 8'd0;
                    row_d = row_q + 2'd1;
                    if (row_q == 2'd3) begin
                        state_d = ST_COMPARE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_SCAN;
                cnt_d   = 8'd0;
                if (scan_buf_q != cand_q) begin
                    // Any difference restarts the debounce run with this scan as #1.
                    cand_d   = scan_buf_q;
                    stable_d = 4'd1;
                end else if (stable_q == DEB_LAST) begin
                    // Publish; strobe only if the visible map actually changes.
                    stable_d = DEB_FULL;
                    key_d    = cand_q;
                    strobe_d = (cand_q != key_q);
                end else if (stable_q < DEB_LAST) begin
                    stable_d = stable_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_SCAN;
            row_q      <= 2'd0;
            cnt_q      <= 8'd0;
            scan_buf_q <= '0;
            cand_q     <= '0;
            stable_q   <= 4'd0;
            key_q      <= '0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            scan_buf_q <= scan_buf_d;
            cand_q     <= cand_d;
            stable_q   <= stable_d;
            key_q      <= key_d;
            strobe_q   <= strobe_d;
        end
    end

    // row_q is already 0 during COMPARE, but the idle drive is made explicit.
    assign kp.row_out    = (state_q == ST_COMPARE) ? 4'b0001 : row_onehot(row_q);
    assign kp.key_state  = key_q;
    assign kp.key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SETTLE_CYCLES=4, DEBOUNCE_SCANS=3.
// A behavioural key matrix turns the pressed-key map plus row_out into col_in.
module tb_keypad_scanner;

    localparam int SP = 17;

    logic        clk;
    logic        nrst;
    logic [15:0] keys;
    int          n_vec;
    int          n_bad;
    int          n_strobe;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .kp   (kif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        kif.col_in = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (kif.row_out[r] && keys[r*4+c]) kif.col_in[c] = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (kif.key_strobe === 1'b1) n_strobe <= n_strobe + 1;
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int s0;

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        n_strobe = 0;
        keys     = 16'h0000;
        nrst     = 1'b0;

        // Reset state
        tick(3);
        check_vec("rst_row", 32'(kif.row_out), 32'h1);
        check_vec("rst_key", 32'(kif.key_state), 32'h0);
        check_vec("rst_stb", 32'(kif.key_strobe), 32'h0);

        // Idle scanning: row sequence and scan period
        @(negedge clk);
        nrst = 1'b1;
        tick(3);
        check_vec("row0_e3", 32'(kif.row_out), 32'h1);
        tick(1);
        check_vec("row1_e4", 32'(kif.row_out), 32'h2);
        tick(4);
        check_vec("row2_e8", 32'(kif.row_out), 32'h4);
        tick(4);
        check_vec("row3_e12", 32'(kif.row_out), 32'h8);
        tick(4);
        check_vec("cmp_e16", 32'(kif.row_out), 32'h1);
        tick(4);
        check_vec("row0_e20", 32'(kif.row_out), 32'h1);
        tick(1);
        check_vec("row1_e21", 32'(kif.row_out), 32'h2);
        tick(SP * 8);
        check_vec("idle_key", 32'(kif.key_state), 32'h0);
        check_vec("idle_stb_cnt", 32'(n_strobe), 32'h0);

        // Single key (row1,col2) held
        keys = 16'h0040;
        tick(SP * 2);
        check_vec("k40_early", 32'(kif.key_state), 32'h0);
        tick(SP * 4);
        check_vec("k40_set", 32'(kif.key_state), 32'h40);
        check_vec("k40_stb", 32'(n_strobe), 32'h1);
        tick(SP * 3);
        check_vec("k40_hold_stb", 32'(n_strobe), 32'h1);
        check_vec("k40_hold", 32'(kif.key_state), 32'h40);
        keys = 16'h0000;
        tick(SP * 6);
        check_vec("k40_rel", 32'(kif.key_state), 32'h0);
        check_vec("k40_rel_stb", 32'(n_strobe), 32'h2);

        // Bounce: key toggled every scan for 8 scans
        for (int i = 0; i < 8; i++) begin
            keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
            tick(SP);
            check_vec("bounce_key", 32'(kif.key_state), 32'h0);
        end
        keys = 16'h0000;
        tick(SP * 4);
        check_vec("bounce_stb", 32'(n_strobe), 32'h2);

        // Two simultaneous keys (0,0) and (3,3)
        keys = 16'h8001;
        tick(SP * 6);
        check_vec("k8001_set", 32'(kif.key_state), 32'h8001);
        check_vec("k8001_stb", 32'(n_strobe), 32'h3);
        keys = 16'h0000;
        tick(SP * 2);
        check_vec("k8001_early", 32'(kif.key_state), 32'h8001);
        tick(SP * 4);
        check_vec("k8001_rel", 32'(kif.key_state), 32'h0);
        check_vec("k8001_rel_stb", 32'(n_strobe), 32'h4);

        // Reset in the middle of row 2 with a key held
        keys = 16'h0040;
        tick(SP * 6);
        check_vec("pre_rst_key", 32'(kif.key_state), 32'h40);
        for (int i = 0; i < 40 && kif.row_out != 4'b0100; i++) tick(1);
        check_vec("find_row2", 32'(kif.row_out), 32'h4);
        tick(2);
        nrst = 1'b0;
        #1;
        check_vec("mid_rst_key", 32'(kif.key_state), 32'h0);
        check_vec("mid_rst_row", 32'(kif.row_out), 32'h1);
        check_vec("mid_rst_stb", 32'(kif.key_strobe), 32'h0);
        s0 = n_strobe;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        tick(50);
        check_vec("rec_e50_key", 32'(kif.key_state), 32'h0);
        tick(1);
        check_vec("rec_e51_key", 32'(kif.key_state), 32'h40);
        check_vec("rec_e51_stb", 32'(kif.key_strobe), 32'h1);
        tick(1);
        check_vec("rec_e52_stb", 32'(kif.key_strobe), 32'h0);
        check_vec("rec_stb_cnt", 32'(n_strobe - s0), 32'h1);

        // Column changes at arbitrary times relative to the sample edges
        keys = 16'h0000;
        tick(SP * 6);
        for (int i = 0; i < 60; i++) begin
            keys[2] = ~keys[2];
            #($urandom_range(3, 40));
            check_vec("async_x", 32'($isunknown({kif.row_out, kif.key_state, kif.key_strobe})), 32'h0);
        end
        keys = 16'h0004;
        tick(SP * 6);
        check_vec("async_final", 32'(kif.key_state), 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: clocks each row is driven before its columns are sampled; legal range 2..255.
REQ-002 Parameter DEBOUNCE_SCANS, default 4: consecutive identical full scans required before the output updates; legal range 2..15.
REQ-003 clk  input  1  single system clock; all flops rise on posedge clk.
REQ-004 nrst  input  1  reset, asynchronous and active-low.
REQ-005 col_in  input  4  raw asynchronous column sense; 1 = key closed in the driven row.
REQ-006 row_out  output  4  one-hot row drive; bit r high = row r driven.
REQ-007 key_state  output  16  debounced pressed map, bit (row*4+col); feeds the core's keypad_input.
REQ-008 key_strobe  output  1  one-cycle pulse coincident with any change of key_state.

Function
REQ-009 col_in SHALL pass through a 2-flop synchronizer; only synchronized columns are sampled.
REQ-010 FSM states SCAN and COMPARE; reset state SCAN, row index 0, settle counter 0.
REQ-011 SCAN: row_out = one-hot(row index); settle counter increments 0..SETTLE_CYCLES-1 each clock.
REQ-012 SCAN, counter == SETTLE_CYCLES-1: sync cols written to scan_buf[row*4 +: 4]; counter -> 0; row index +1.
REQ-013 Sample taken with row index 3: row index wraps to 0; FSM -> COMPARE next cycle.
REQ-014 COMPARE lasts exactly one cycle: row_out = 4'b0001, counter held at 0; then -> SCAN.
REQ-015 Full scan period = 4*SETTLE_CYCLES+1 clocks.
REQ-016 COMPARE, scan_buf != candidate: candidate <= scan_buf; stable_cnt <= 1.
REQ-017 COMPARE, scan_buf == candidate, stable_cnt < DEBOUNCE_SCANS-1: stable_cnt +1.
REQ-018 COMPARE, scan_buf == candidate, stable_cnt == DEBOUNCE_SCANS-1: stable_cnt <= DEBOUNCE_SCANS; key_state <= candidate.
REQ-019 COMPARE, scan_buf == candidate, stable_cnt == DEBOUNCE_SCANS: stable_cnt saturates; key_state unchanged.
REQ-020 key_strobe registered; high exactly the cycle key_state takes a new differing value; low otherwise, including a REQ-018 update with equal value.
REQ-021 Multiple simultaneous keys SHALL be reported as-is; no ghosting suppression or priority.
REQ-022 Any mismatch in a scan SHALL restart debounce; a bounce shorter than DEBOUNCE_SCANS scans never reaches key_state.
REQ-023 Latency: stable col_in change reaches key_state within (DEBOUNCE_SCANS+1) scan periods + 3 clocks.

Reset
REQ-024 nrst low SHALL immediately force: row_out = 4'b0001, key_state = 0, key_strobe = 0, scan_buf = 0, candidate = 0, stable_cnt = 0, synchronizer flops = 0, FSM = SCAN, counters = 0.
REQ-025 Reset mid-scan SHALL discard partial scan_buf; scanning restarts at row 0, count 0 on the first clock after release.

Structure
REQ-026 Shared package keypad_pkg holds: state enum (SCAN, COMPARE), constants KP_ROWS = 4, KP_COLS = 4.
REQ-027 One sub-module, sync2 (parameterized-width two-flop synchronizer, async active-low reset), instantiated for col_in.
REQ-028 All other logic in keypad_scanner; no latches, no combinational path col_in -> any output.

Verification (SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, scan period 17 clocks)
REQ-029 Reset release, col_in = 0 for 10 scans -> row_out cycles 0001,0010,0100,1000 (4 clocks each) + COMPARE; key_state = 0x0000, key_strobe never high.
REQ-030 col_in = 4'b0100 only while row_out = 0010, held -> key_state = 0x0040 after 3rd identical scan; key_strobe one pulse; none thereafter.
REQ-031 Same key toggled every other scan for 8 scans -> key_state stays 0x0000; no strobe.
REQ-032 Keys (0,0) and (3,3) held -> key_state = 0x8001; release both -> key_state = 0x0000 after 3 scans, one strobe per change.
REQ-033 Key held, key_state = 0x0040; assert nrst mid row 2 -> key_state = 0, row_out = 0001 during reset; after release key_state returns to 0x0040 after 3 scans.
REQ-034 col_in changes within 2 clocks of a sample edge -> no X on outputs; key_state reflects one consistent value per row.
